// File: rtl/ballot_frame_rx.sv
// Serial ballot frame receiver: deserialises start/A1..A7/[parity]/stop and votes by threshold.
// Optional feature: define PARITY_CHECK_EN to expect and check an even-parity bit before stop.
module ballot_frame_rx #(
    parameter int unsigned BIT_CYCLES = 4,
    parameter int unsigned THRESH     = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sin_i,
    output logic [6:0] votes_o,
    output logic       out_o,
    output logic       valid_o,
    output logic       ferr_o,
    output logic       perr_o
);

    localparam int unsigned CNT_W    = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned HALF     = BIT_CYCLES / 2;
    localparam logic [2:0]  THRESH_W = 3'(THRESH);

`ifdef PARITY_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [6:0]       shadow_q, shadow_d;
    logic [2:0]       ones_q, ones_d;
    logic [6:0]       votes_q, votes_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
`ifdef PARITY_CHECK_EN
    logic             par_bad_q, par_bad_d;
    logic             perr_q, perr_d;
`endif

    // Start bit is sampled mid-bit; later bits every BIT_CYCLES after that.
    logic start_smp_c;
    logic bit_smp_c;
    assign start_smp_c = (cnt_q == CNT_W'(HALF - 1));
    assign bit_smp_c   = (cnt_q == CNT_W'(BIT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_d     = bit_q;
        shadow_d  = shadow_q;
        ones_d    = ones_q;
        votes_d   = votes_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef PARITY_CHECK_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!sin_i) begin
                    state_d   = S_START;
                    bit_d     = '0;
                    shadow_d  = '0;
                    ones_d    = '0;
`ifdef PARITY_CHECK_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            S_START: begin
                if (start_smp_c) begin
                    cnt_d   = '0;
                    state_d = sin_i ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_smp_c) begin
                    cnt_d    = '0;
                    shadow_d = {sin_i, shadow_q[6:1]};
                    ones_d   = ones_q + 3'(sin_i);
                    bit_d    = bit_q + 3'd1;
                    if (bit_q == 3'd6) begin
`ifdef PARITY_CHECK_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            S_PARITY: begin
                if (bit_smp_c) begin
                    cnt_d     = '0;
                    par_bad_d = sin_i ^ (^shadow_q);
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_smp_c) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (!sin_i) begin
                        ferr_d = 1'b1;
`ifdef PARITY_CHECK_EN
                    end else if (par_bad_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        valid_d = 1'b1;
                        votes_d = shadow_q;
                        out_d   = (ones_q >= THRESH_W);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shadow_q  <= '0;
            ones_q    <= '0;
            votes_q   <= '0;
            out_q     <= 1'b0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shadow_q  <= shadow_d;
            ones_q    <= ones_d;
            votes_q   <= votes_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef PARITY_CHECK_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign votes_o = votes_q;
    assign out_o   = out_q;
    assign valid_o = valid_q;
    assign ferr_o  = ferr_q;
`ifdef PARITY_CHECK_EN
    assign perr_o  = perr_q;
`else
    assign perr_o  = 1'b0;
`endif

endmodule

// File: tb/tb_ballot_frame_rx.sv
// Bench for ballot_frame_rx: frame-level reference model predicting pulse kind, cycle and held votes.
module tb_ballot_frame_rx;

    localparam int unsigned B      = 4;
    localparam int unsigned H      = B / 2;
    localparam int unsigned THRESH = 4;
`ifdef PARITY_CHECK_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       sin;
    logic [6:0] votes_o;
    logic       out_o, valid_o, ferr_o, perr_o;

    ballot_frame_rx #(.BIT_CYCLES(B), .THRESH(THRESH)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .sin_i   (sin),
        .votes_o (votes_o),
        .out_o   (out_o),
        .valid_o (valid_o),
        .ferr_o  (ferr_o),
        .perr_o  (perr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         kind;   // 1 valid, 2 framing error, 3 parity error
        logic [6:0] votes;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [6:0] m_votes = '0;
    logic       m_out   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock and compare every output against the model.
    task automatic tick();
        int   kind = 0;
        logic rst_s;
        ev_t  e;
        rst_s = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_s) begin
            exp_q.delete();
            m_votes = '0;
            m_out   = 1'b0;
        end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e    = exp_q.pop_front();
            kind = e.kind;
            if (kind == 1) begin
                m_votes = e.votes;
                m_out   = ($countones(e.votes) >= THRESH);
            end
        end
        check_eq("valid", valid_o, kind == 1);
        check_eq("ferr",  ferr_o,  kind == 2);
        check_eq("perr",  perr_o,  kind == 3);
        check_eq("votes", votes_o, m_votes);
        check_eq("out",   out_o,   m_out);
    endtask

    // Line goes low after cycle cs; first low sample is t0=cs+1, stop sampled at t0+H+(NBITS-1)*B.
    task automatic send_frame(input logic [6:0] v, input bit par_bad, input bit stop_bad, input int gap);
        logic [9:0] bits;
        ev_t        e;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 7; i++) bits[i+1] = v[i];
`ifdef PARITY_CHECK_EN
        bits[8] = (^v) ^ par_bad;
        bits[9] = !stop_bad;
        e.kind  = stop_bad ? 2 : (par_bad ? 3 : 1);
`else
        bits[8] = !stop_bad;
        e.kind  = stop_bad ? 2 : 1;
`endif
        e.cyc   = cyc + 1 + int'(H) + (NBITS - 1) * int'(B);
        e.votes = v;
        exp_q.push_back(e);
        for (int i = 0; i < NBITS; i++) begin
            sin = bits[i];
            repeat (B) tick();
        end
        sin = 1'b1;
        // After a low stop bit the line must idle a full bit so the tail is rejected as a glitch.
        repeat ((stop_bad && gap < int'(B)) ? int'(B) : gap) tick();
    endtask

    task automatic glitch();
        sin = 1'b0;
        tick();
        sin = 1'b1;
        repeat (B) tick();
    endtask

    initial begin
        int r;
        rst = 1'b1;
        sin = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        send_frame(7'h07, 1'b0, 1'b0, 3);          // three votes: below threshold
        send_frame(7'h0F, 1'b0, 1'b0, 3);          // four votes: at threshold
        glitch();
        send_frame(7'h00, 1'b0, 1'b0, 2);
        send_frame(7'h7F, 1'b0, 1'b0, 2);
        send_frame(7'h0F, 1'b0, 1'b0, 2);
        send_frame(7'h70, 1'b0, 1'b1, 4);          // bad stop: votes hold at 0x0F
`ifdef PARITY_CHECK_EN
        send_frame(7'h07, 1'b1, 1'b0, 4);          // bad parity: discarded
`endif
        send_frame(7'h07, 1'b0, 1'b0, 0);          // back-to-back pair
        send_frame(7'h0F, 1'b0, 1'b0, 4);

        // Reset in the middle of a frame drops it and clears the outputs.
        sin = 1'b0;
        repeat (B) tick();
        sin = 1'b1;
        repeat (2 * B) tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3 * B) tick();
        send_frame(7'h5A, 1'b0, 1'b0, 2);

        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                glitch();
            end else begin
                send_frame(7'($urandom), r == 1, r == 2,
                           ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6)));
            end
        end
        repeat (2 * B) tick();

        check_eq("pending", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
